// File: rtl/temp_conv_pkg.sv
// Shared types, offsets and floor-division helpers for the temperature converter.
// Rounding is selected in the top-level by the TEMP_CONV_ROUND_EN macro.
package temp_conv_pkg;

  typedef enum logic [1:0] {
    C2F = 2'd0,
    F2C = 2'd1,
    C2K = 2'd2,
    K2C = 2'd3
  } conv_mode_t;

  localparam int FAHR_OFFSET   = 32;
  localparam int KELVIN_OFFSET = 273;

  // Helpers work on a fixed 64-bit signed type so any DATA_W can use them.
  typedef logic signed [63:0] wide_t;

  // SV division truncates toward zero; step back by one when a negative
  // dividend leaves a remainder so the quotient rounds toward -infinity.
  function automatic wide_t floor_div5(input wide_t x);
    wide_t q;
    q = x / 64'sd5;
    if ((x - q * 64'sd5) < 64'sd0) begin
      q = q - 64'sd1;
    end
    return q;
  endfunction

  function automatic wide_t floor_div9(input wide_t x);
    wide_t q;
    q = x / 64'sd9;
    if ((x - q * 64'sd9) < 64'sd0) begin
      q = q - 64'sd1;
    end
    return q;
  endfunction

endpackage

// File: rtl/temp_conv_sat.sv
// Combinational clamp of a wide signed value into DATA_W bits, flagging when
// the value had to be clamped.
module temp_conv_sat #(
  parameter int DATA_W = 12,
  parameter int IN_W   = 18
) (
  input  logic signed [IN_W-1:0]   i_wide,
  output logic signed [DATA_W-1:0] o_temp,
  output logic                     o_sat
);

  // The value fits exactly when every bit from the target sign bit upward agrees.
  logic [IN_W-DATA_W:0] w_hi;
  assign w_hi = i_wide[IN_W-1:DATA_W-1];

  always_comb begin
    o_sat  = !((&w_hi) || !(|w_hi));
    o_temp = i_wide[DATA_W-1:0];
    if (o_sat) begin
      o_temp = i_wide[IN_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                              : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/temp_conv_pipe.sv
// Three-stage pipelined C/F/K temperature converter with valid/ready handshake.
// Define TEMP_CONV_ROUND_EN for round-to-nearest on C2F/F2C instead of floor.
module temp_conv_pipe
  import temp_conv_pkg::*;
#(
  parameter  int DATA_W = 12,
  parameter  int CH_N   = 4,
  localparam int CH_W   = (CH_N > 1) ? $clog2(CH_N) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_temp,
  input  logic [1:0]               in_mode,
  input  logic [CH_W-1:0]          in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_temp,
  output logic [CH_W-1:0]          out_tag,
  output logic                     out_sat
);

  localparam int WW = DATA_W + 6;

`ifdef TEMP_CONV_ROUND_EN
  localparam wide_t C2F_BIAS = 64'sd2;
  localparam wide_t F2C_BIAS = 64'sd4;
`else
  localparam wide_t C2F_BIAS = 64'sd0;
  localparam wide_t F2C_BIAS = 64'sd0;
`endif

  logic                     r_vld_p1, r_vld_p2, r_vld_p3;
  logic signed [WW-1:0]     r_x_p1, r_x_p2;
  conv_mode_t               r_mode_p1, r_mode_p2;
  logic [CH_W-1:0]          r_tag_p1, r_tag_p2, r_tag_p3;
  logic signed [DATA_W-1:0] r_temp_p3;
  logic                     r_sat_p3;

  logic                     w_advance;
  logic signed [WW-1:0]     w_ext_p0, w_x_p0;
  wide_t                    w_num5_p1, w_num9_p1;
  logic signed [WW-1:0]     w_q_p1;
  logic signed [WW-1:0]     w_off_p2, w_sum_p2;
  logic signed [DATA_W-1:0] w_sat_temp_p2;
  logic                     w_sat_p2;

  // Whole pipe moves in lockstep; only a held result in S3 stalls it.
  assign w_advance = !r_vld_p3 || out_ready;
  assign in_ready  = w_advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_vld_p3 <= 1'b0;
    end else if (w_advance) begin
      r_vld_p1 <= in_valid;
      r_vld_p2 <= r_vld_p1;
      r_vld_p3 <= r_vld_p2;
    end
  end

  // ---- S1: capture, remove the Fahrenheit offset before scaling ----
  always_comb begin
    w_ext_p0 = WW'(in_temp);
    w_x_p0   = w_ext_p0;
    if (conv_mode_t'(in_mode) == F2C) begin
      w_x_p0 = w_ext_p0 - WW'(FAHR_OFFSET);
    end
  end

  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_x_p1    <= w_x_p0;
      r_mode_p1 <= conv_mode_t'(in_mode);
      r_tag_p1  <= in_tag;
    end
  end

  // ---- S2: scale and floor-divide; Kelvin modes pass straight through ----
  always_comb begin
    w_num5_p1 = wide_t'(r_x_p1) * 64'sd9 + C2F_BIAS;
    w_num9_p1 = wide_t'(r_x_p1) * 64'sd5 + F2C_BIAS;
    case (r_mode_p1)
      C2F:     w_q_p1 = WW'(floor_div5(w_num5_p1));
      F2C:     w_q_p1 = WW'(floor_div9(w_num9_p1));
      default: w_q_p1 = r_x_p1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_x_p2    <= w_q_p1;
      r_mode_p2 <= r_mode_p1;
      r_tag_p2  <= r_tag_p1;
    end
  end

  // ---- S3: apply output offset, clamp into DATA_W ----
  always_comb begin
    case (r_mode_p2)
      C2F:     w_off_p2 = WW'(FAHR_OFFSET);
      C2K:     w_off_p2 = WW'(KELVIN_OFFSET);
      K2C:     w_off_p2 = -WW'(KELVIN_OFFSET);
      default: w_off_p2 = '0;
    endcase
    w_sum_p2 = r_x_p2 + w_off_p2;
  end

  temp_conv_sat #(
    .DATA_W (DATA_W),
    .IN_W   (WW)
  ) u_sat (
    .i_wide (w_sum_p2),
    .o_temp (w_sat_temp_p2),
    .o_sat  (w_sat_p2)
  );

  // Output register only loads on a real sample so idle outputs stay quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_temp_p3 <= '0;
      r_tag_p3  <= '0;
      r_sat_p3  <= 1'b0;
    end else if (w_advance && r_vld_p2) begin
      r_temp_p3 <= w_sat_temp_p2;
      r_tag_p3  <= r_tag_p2;
      r_sat_p3  <= w_sat_p2;
    end
  end

  assign out_valid = r_vld_p3;
  assign out_temp  = r_temp_p3;
  assign out_tag   = r_tag_p3;
  assign out_sat   = r_sat_p3;

endmodule

// File: tb/tb_temp_conv_pipe.sv
// Self-checking bench for temp_conv_pipe: directed table, backpressure, reset
// and randomized traffic scored against a real-arithmetic reference model.
module tb_temp_conv_pipe;

  localparam int DATA_W = 12;
  localparam int CH_N   = 4;
  localparam int CH_W   = 2;
  localparam int MAXV   = (1 << (DATA_W - 1)) - 1;
  localparam int MINV   = -(1 << (DATA_W - 1));

`ifdef TEMP_CONV_ROUND_EN
  localparam real RB5 = 2.0;
  localparam real RB9 = 4.0;
`else
  localparam real RB5 = 0.0;
  localparam real RB9 = 0.0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_temp;
  logic [1:0]               in_mode;
  logic [CH_W-1:0]          in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_temp;
  logic [CH_W-1:0]          out_tag;
  logic                     out_sat;

  temp_conv_pipe #(.DATA_W(DATA_W), .CH_N(CH_N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_temp   (in_temp),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_temp  (out_temp),
    .out_tag   (out_tag),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int              acc;
    int              temp;
    logic [CH_W-1:0] tag;
    logic            sat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_hold = -1;
  bit   held     = 1'b0;
  bit   dir_en   = 1'b0;
  int   dir_exp  = 0;
  bit   dir_sat  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: plain real arithmetic with explicit floor, then clamp.
  function automatic int ref_conv(input int t, input int m, output bit s);
    int v;
    case (m)
      0:       v = int'($floor((9.0 * t + RB5) / 5.0)) + 32;
      1:       v = int'($floor((5.0 * (t - 32) + RB9) / 9.0));
      2:       v = t + 273;
      default: v = t - 273;
    endcase
    s = 1'b0;
    if (v > MAXV) begin
      v = MAXV;
      s = 1'b1;
    end else if (v < MINV) begin
      v = MINV;
      s = 1'b1;
    end
    return v;
  endfunction

  // Monitor samples at negedge: inputs and outputs are stable and show the
  // transfers that will happen at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    bit   s;
    if (!rst_n) begin
      sb.delete();
      held = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_temp", out_temp, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_out_sat", out_sat, 0);
      check("rst_in_ready", in_ready, 1);
    end else begin
      check("in_ready_rule", in_ready, (!out_valid || out_ready));
      if (held) check("hold_valid", out_valid, 1);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out", out_valid, 0);
        end else begin
          e = sb[0];
          check("out_temp", out_temp, e.temp);
          check("out_tag", out_tag, e.tag);
          check("out_sat", out_sat, e.sat);
          if (out_ready) begin
            if (e.acc > last_hold) check("latency", cyc - e.acc, 3);
            void'(sb.pop_front());
          end
        end
      end
      held = out_valid && !out_ready;
      if (held) last_hold = cyc;
      if (in_valid && in_ready) begin
        e.acc = cyc;
        e.tag = in_tag;
        if (dir_en) begin
          e.temp = dir_exp;
          e.sat  = dir_sat;
        end else begin
          e.temp = ref_conv(int'(in_temp), int'(in_mode), s);
          e.sat  = s;
        end
        sb.push_back(e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the transfer edge.
  task automatic send(input int mode, input int temp, input int tag,
                      input bit den, input int dexp, input bit dsat);
    int n;
    in_valid = 1'b1;
    in_mode  = 2'(mode);
    in_temp  = DATA_W'(temp);
    in_tag   = CH_W'(tag);
    dir_en   = den;
    dir_exp  = dexp;
    dir_sat  = dsat;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready || n >= 500) break;
      n++;
    end
    if (!in_ready) check("send_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dir_en   = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Directed table: mode, input, expected, sat
  int d_mode[17] = '{0, 0, 0, 0, 0,  1, 1, 1, 1,  2, 3, 3,  0, 1, 2, 3,  2};
  int d_in[17]   = '{25, -40, 100, 1, -1,  100, 0, -40, 32,  1900, 300, -2048,
                     0, 212, 0, 273,  -2048};
`ifdef TEMP_CONV_ROUND_EN
  int d_exp[17]  = '{77, -40, 212, 34, 30,  38, -18, -40, 0,  2047, 27, -2048,
                     32, 100, 273, 0,  -1775};
`else
  int d_exp[17]  = '{77, -40, 212, 33, 30,  37, -18, -40, 0,  2047, 27, -2048,
                     32, 100, 273, 0,  -1775};
`endif
  bit d_sat[17]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 1,  0, 0, 0, 0,  0};

  initial begin
    bit done;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_temp   = '0;
    in_mode   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed conversions, back-to-back (includes the mixed-mode run)
    for (int i = 0; i < 17; i++) begin
      send(d_mode[i], d_in[i], i % CH_N, 1'b1, d_exp[i], d_sat[i]);
    end
    drain();

    // Backpressure: continuous stream, out_ready low for 5 cycles mid-stream
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          send(i % 4, 40 * i - 300, i % CH_N, 1'b0, 0, 1'b0);
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three samples in flight
    for (int i = 0; i < 3; i++) send(2, 10 * i, i, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    send(0, 25, 3, 1'b1, 77, 1'b0);
    drain();

    // Randomized traffic with random gaps and random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send($urandom_range(0, 3), int'($urandom_range(0, 4095)) - 2048,
               $urandom_range(0, CH_N - 1), 1'b0, 0, 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
